// File: rtl/dcalc_vector_dot3_seq.sv
// dcalc_vector_dot3_seq
// Sequences a 3-element single-precision dot product, a0*b0 + a1*b1 + a2*b2,
// through an external multiplier and an external adder. This block starts every
// transfer on the stb/ack float-core protocol and performs no arithmetic itself.
// Accumulation order is ((p0 + p1) + p2).
//
// Ports
//   clk, rst                  clock; asynchronous active-low reset
//   start                     request a computation (sampled only in idle)
//   a0..a2, b0..b2            operands, captured when start is accepted
//   result                    last completed dot product
//   done_flag / error         one-cycle pulses: completion / watchdog abort
//   busy                      high in every state except idle
//   mul_a/b, *_stb, *_ack     operand channels to the multiplier
//   mul_z, _stb, _ack         product return channel
//   add_a/b, *_stb, *_ack     operand channels to the adder
//   add_z, _stb, _ack         sum return channel
module dcalc_vector_dot3_seq #(
  parameter int unsigned WATCHDOG = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic [31:0] a2,
  input  logic [31:0] b0,
  input  logic [31:0] b1,
  input  logic [31:0] b2,
  output logic [31:0] result,
  output logic        done_flag,
  output logic        error,
  output logic        busy,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_a_stb,
  output logic        mul_b_stb,
  input  logic        mul_a_ack,
  input  logic        mul_b_ack,
  input  logic [31:0] mul_z,
  input  logic        mul_z_stb,
  output logic        mul_z_ack,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_a_stb,
  output logic        add_b_stb,
  input  logic        add_a_ack,
  input  logic        add_b_ack,
  input  logic [31:0] add_z,
  input  logic        add_z_stb,
  output logic        add_z_ack
);

  typedef enum logic [2:0] {
    StIdle,
    StMulTx,
    StMulRx,
    StAddTx,
    StAddRx,
    StDone,
    StErr
  } state_e;

  state_e      state_q;
  logic [1:0]  idx_q;
  logic [15:0] wd_q;
  logic [31:0] a_q [3];
  logic [31:0] b_q [3];
  logic [31:0] acc_q;

  logic       hs_state;
  logic       hs_advance;
  logic       wd_expired;
  logic       mul_pair_ok;
  logic       add_pair_ok;
  logic [1:0] nxt_idx;

  function automatic logic [31:0] pick(input logic [1:0] i, input logic [31:0] x0,
                                       input logic [31:0] x1, input logic [31:0] x2);
    unique case (i)
      2'd0:    pick = x0;
      2'd1:    pick = x1;
      default: pick = x2;
    endcase
  endfunction

  // An operand counts as delivered once its stb has dropped, or if it is
  // being acked on this edge; both sides may finish on different cycles.
  assign mul_pair_ok = (!mul_a_stb || mul_a_ack) && (!mul_b_stb || mul_b_ack);
  assign add_pair_ok = (!add_a_stb || add_a_ack) && (!add_b_stb || add_b_ack);
  assign nxt_idx     = idx_q + 2'd1;
  assign wd_expired  = (wd_q == 16'(WATCHDOG - 1));
  assign busy        = (state_q != StIdle);

  always_comb begin
    hs_state   = 1'b0;
    hs_advance = 1'b0;
    unique case (state_q)
      StMulTx: begin hs_state = 1'b1; hs_advance = mul_pair_ok;             end
      StMulRx: begin hs_state = 1'b1; hs_advance = mul_z_stb && mul_z_ack;  end
      StAddTx: begin hs_state = 1'b1; hs_advance = add_pair_ok;             end
      StAddRx: begin hs_state = 1'b1; hs_advance = add_z_stb && add_z_ack;  end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      idx_q     <= 2'd0;
      wd_q      <= 16'd0;
      acc_q     <= 32'd0;
      for (int k = 0; k < 3; k++) begin
        a_q[k] <= 32'd0;
        b_q[k] <= 32'd0;
      end
      result    <= 32'd0;
      done_flag <= 1'b0;
      error     <= 1'b0;
      mul_a     <= 32'd0;
      mul_b     <= 32'd0;
      mul_a_stb <= 1'b0;
      mul_b_stb <= 1'b0;
      mul_z_ack <= 1'b0;
      add_a     <= 32'd0;
      add_b     <= 32'd0;
      add_a_stb <= 1'b0;
      add_b_stb <= 1'b0;
      add_z_ack <= 1'b0;
    end else begin
      done_flag <= 1'b0;
      error     <= 1'b0;

      if (hs_state && !hs_advance && wd_expired) begin
        // Abort: release every channel; result keeps its previous value.
        state_q   <= StErr;
        wd_q      <= 16'd0;
        error     <= 1'b1;
        mul_a_stb <= 1'b0;
        mul_b_stb <= 1'b0;
        mul_z_ack <= 1'b0;
        add_a_stb <= 1'b0;
        add_b_stb <= 1'b0;
        add_z_ack <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              a_q[0]    <= a0;
              a_q[1]    <= a1;
              a_q[2]    <= a2;
              b_q[0]    <= b0;
              b_q[1]    <= b1;
              b_q[2]    <= b2;
              idx_q     <= 2'd0;
              wd_q      <= 16'd0;
              mul_a     <= a0;
              mul_b     <= b0;
              mul_a_stb <= 1'b1;
              mul_b_stb <= 1'b1;
              state_q   <= StMulTx;
            end
          end

          StMulTx: begin
            if (hs_advance) begin
              mul_a_stb <= 1'b0;
              mul_b_stb <= 1'b0;
              mul_z_ack <= 1'b1;
              wd_q      <= 16'd0;
              state_q   <= StMulRx;
            end else begin
              if (mul_a_stb && mul_a_ack) mul_a_stb <= 1'b0;
              if (mul_b_stb && mul_b_ack) mul_b_stb <= 1'b0;
              wd_q <= wd_q + 16'd1;
            end
          end

          StMulRx: begin
            if (hs_advance) begin
              mul_z_ack <= 1'b0;
              wd_q      <= 16'd0;
              if (idx_q == 2'd0) begin
                // First product seeds the accumulator directly.
                acc_q     <= mul_z;
                idx_q     <= 2'd1;
                mul_a     <= a_q[1];
                mul_b     <= b_q[1];
                mul_a_stb <= 1'b1;
                mul_b_stb <= 1'b1;
                state_q   <= StMulTx;
              end else begin
                add_a     <= acc_q;
                add_b     <= mul_z;
                add_a_stb <= 1'b1;
                add_b_stb <= 1'b1;
                state_q   <= StAddTx;
              end
            end else begin
              wd_q <= wd_q + 16'd1;
            end
          end

          StAddTx: begin
            if (hs_advance) begin
              add_a_stb <= 1'b0;
              add_b_stb <= 1'b0;
              add_z_ack <= 1'b1;
              wd_q      <= 16'd0;
              state_q   <= StAddRx;
            end else begin
              if (add_a_stb && add_a_ack) add_a_stb <= 1'b0;
              if (add_b_stb && add_b_ack) add_b_stb <= 1'b0;
              wd_q <= wd_q + 16'd1;
            end
          end

          StAddRx: begin
            if (hs_advance) begin
              add_z_ack <= 1'b0;
              acc_q     <= add_z;
              wd_q      <= 16'd0;
              if (idx_q == 2'd2) begin
                result    <= add_z;
                done_flag <= 1'b1;
                state_q   <= StDone;
              end else begin
                idx_q     <= nxt_idx;
                mul_a     <= pick(nxt_idx, a_q[0], a_q[1], a_q[2]);
                mul_b     <= pick(nxt_idx, b_q[0], b_q[1], b_q[2]);
                mul_a_stb <= 1'b1;
                mul_b_stb <= 1'b1;
                state_q   <= StMulTx;
              end
            end else begin
              wd_q <= wd_q + 16'd1;
            end
          end

          StDone: begin
            wd_q    <= 16'd0;
            state_q <= StIdle;
          end

          StErr: begin
            wd_q    <= 16'd0;
            state_q <= StIdle;
          end

          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
